// File: rtl/line_window_if.sv
// Pixel-stream, line-cache and column-output bundle for line_window_ctrl.
//   slave  : controller side (takes pixels and cache read data, drives cache control and columns)
//   master : environment side (pixel source, the two external caches, the column consumer)
// Signals:
//   pix_valid/pix_data/frame_start     raster pixel stream, no back-pressure
//   cache_we/cache_wadx/cache_wdata    write port shared by both caches, per-cache enable
//   cache_radx                         read address shared by both caches
//   cache0_rdata/cache1_rdata          cache read data, one cycle after cache_radx
//   out_valid/out_top/out_mid/out_bot  aligned vertical 3-pixel column
//   out_x/out_y/out_eof                coordinates of out_bot, end-of-frame marker
interface line_window_if;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        frame_start;
    logic [1:0]  cache_we;
    logic [9:0]  cache_wadx;
    logic [7:0]  cache_wdata;
    logic [9:0]  cache_radx;
    logic [7:0]  cache0_rdata;
    logic [7:0]  cache1_rdata;
    logic        out_valid;
    logic [7:0]  out_top;
    logic [7:0]  out_mid;
    logic [7:0]  out_bot;
    logic [9:0]  out_x;
    logic [8:0]  out_y;
    logic        out_eof;

    modport slave (
        input  pix_valid, pix_data, frame_start, cache0_rdata, cache1_rdata,
        output cache_we, cache_wadx, cache_wdata, cache_radx,
        output out_valid, out_top, out_mid, out_bot, out_x, out_y, out_eof
    );

    modport master (
        output pix_valid, pix_data, frame_start, cache0_rdata, cache1_rdata,
        input  cache_we, cache_wadx, cache_wdata, cache_radx,
        input  out_valid, out_top, out_mid, out_bot, out_x, out_y, out_eof
    );
endinterface

// File: rtl/line_window_ctrl.sv
// Sequencer for two external line caches used as a rotating pair of row
// buffers. Each accepted pixel is written into the cache holding row y-2
// while both caches are read at the same column, producing an aligned
// (y-2, y-1, y) column one cycle later.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    line_window_if.slave: pixel stream in, cache control out,
//          cache read data in, column out
// cache_we/cache_wadx/cache_radx/cache_wdata are combinational from the
// accepted pixel; out_top/out_mid pass the cache read data through a mux
// in the output cycle, all other outputs come straight from registers.
module line_window_ctrl #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic         clk,
    input  logic         reset,
    line_window_if.slave bus
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned DW = 8;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    // position counters and row-select; cache[sel_q] holds row y-2
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          sel_q, sel_d;

    // cache address/data, held while the stream stalls
    logic [XW-1:0] adx_q, adx_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // output stage: registered effective coordinates of the emitted pixel
    logic          vld_q;
    logic [XW-1:0] ox_q;
    logic [YW-1:0] oy_q;
    logic          osel_q;
    logic [DW-1:0] obot_q;
    logic          eof_q;
    logic [DW-1:0] top_hold_q;
    logic [DW-1:0] mid_hold_q;

    logic          accept_c;
    logic [XW-1:0] eff_x_c;
    logic [YW-1:0] eff_y_c;
    logic          eff_sel_c;
    logic [DW-1:0] top_c;
    logic [DW-1:0] mid_c;

    // frame_start overrides the counters for the pixel it qualifies
    always_comb begin
        accept_c  = bus.pix_valid && !reset;
        eff_x_c   = bus.frame_start ? '0   : x_q;
        eff_y_c   = bus.frame_start ? '0   : y_q;
        eff_sel_c = bus.frame_start ? 1'b0 : sel_q;
    end

    // next position, row rotation and held cache address/data
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        adx_d   = adx_q;
        wdata_d = wdata_q;
        if (accept_c) begin
            adx_d   = eff_x_c;
            wdata_d = bus.pix_data;
            if (eff_x_c == X_LAST) begin
                // end of row: the oldest-row cache becomes the newest
                x_d   = '0;
                sel_d = ~eff_sel_c;
                y_d   = (eff_y_c == Y_LAST) ? '0 : eff_y_c + YW'(1);
            end else begin
                x_d   = eff_x_c + XW'(1);
                y_d   = eff_y_c;
                sel_d = eff_sel_c;
            end
        end
    end

    // cache control is driven in the acceptance cycle
    always_comb begin
        bus.cache_we    = 2'b00;
        bus.cache_wadx  = adx_d;
        bus.cache_radx  = adx_d;
        bus.cache_wdata = wdata_d;
        if (accept_c) begin
            bus.cache_we = eff_sel_c ? 2'b10 : 2'b01;
        end
    end

    // position and cache-port state
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= 1'b0;
            adx_q   <= '0;
            wdata_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            adx_q   <= adx_d;
            wdata_q <= wdata_d;
        end
    end

    // cache read data lands in the output cycle; rows above the frame read as 0
    always_comb begin
        top_c = '0;
        mid_c = '0;
        if (oy_q >= YW'(2)) begin
            top_c = osel_q ? bus.cache1_rdata : bus.cache0_rdata;
        end
        if (oy_q >= YW'(1)) begin
            mid_c = osel_q ? bus.cache0_rdata : bus.cache1_rdata;
        end
    end

    // output stage; top/mid are captured so they hold once the read data moves on
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= 1'b0;
            ox_q       <= '0;
            oy_q       <= '0;
            osel_q     <= 1'b0;
            obot_q     <= '0;
            eof_q      <= 1'b0;
            top_hold_q <= '0;
            mid_hold_q <= '0;
        end else begin
            vld_q <= accept_c;
            eof_q <= accept_c && (eff_x_c == X_LAST) && (eff_y_c == Y_LAST);
            if (accept_c) begin
                ox_q   <= eff_x_c;
                oy_q   <= eff_y_c;
                osel_q <= eff_sel_c;
                obot_q <= bus.pix_data;
            end
            if (vld_q) begin
                top_hold_q <= top_c;
                mid_hold_q <= mid_c;
            end
        end
    end

    always_comb begin
        bus.out_valid = vld_q;
        bus.out_x     = ox_q;
        bus.out_y     = oy_q;
        bus.out_bot   = obot_q;
        bus.out_eof   = eof_q;
        bus.out_top   = vld_q ? top_c : top_hold_q;
        bus.out_mid   = vld_q ? mid_c : mid_hold_q;
    end

    // both caches must never be written in the same cycle
    a_we_onehot: assert property (@(posedge clk) disable iff (reset) bus.cache_we != 2'b11);

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl at WIDTH=4, HEIGHT=4. Holds a frame-image
// model and two read-before-write cache models; one negedge process
// compares every output against the model, and directed scenarios add
// hand-computed literal checks.
module tb_line_window_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;

    typedef struct packed {
        logic       v;
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic       eof;
    } col_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    line_window_if bus ();

    line_window_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // external caches: registered read, old data on same-address write
    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];
    always @(posedge clk) begin
        bus.cache0_rdata <= mem0[bus.cache_radx];
        bus.cache1_rdata <= mem1[bus.cache_radx];
        if (bus.cache_we[0]) mem0[bus.cache_wadx] <= bus.cache_wdata;
        if (bus.cache_we[1]) mem1[bus.cache_wadx] <= bus.cache_wdata;
    end

    int n_pass = 0;
    int n_total = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // model: image of the current frame indexed by row and column
    logic [7:0] img [H][W];
    int         mp;          // linear position in the frame
    logic       msel;        // parity of rows completed since frame start/reset
    col_t       cur, nxt;    // column shown now / column shown after the next edge
    logic [1:0] e_we;
    logic [9:0] e_adx;
    logic [7:0] e_wdata;
    logic       chk_en = 1'b0;
    logic       rst_was = 1'b0;

    col_t       col_log [$];
    logic [1:0] we_log [$];
    col_t       frame_a [$];

    task automatic step(input logic v, input logic fs, input logic [7:0] d);
        int p, ex, ey;
        logic es;
        @(posedge clk);
        cur = nxt;
        if (rst_was) begin
            e_adx   = '0;
            e_wdata = '0;
            rst_was = 1'b0;
        end
        #1;
        reset           = 1'b0;
        bus.pix_valid   = v;
        bus.frame_start = fs;
        bus.pix_data    = d;
        if (v) begin
            p  = fs ? 0 : mp;
            es = fs ? 1'b0 : msel;
            ex = p % W;
            ey = p / W;
            e_we    = es ? 2'b10 : 2'b01;
            e_adx   = 10'(ex);
            e_wdata = d;
            nxt.v   = 1'b1;
            nxt.x   = 10'(ex);
            nxt.y   = 9'(ey);
            nxt.top = (ey >= 2) ? img[ey-2][ex] : 8'h00;
            nxt.mid = (ey >= 1) ? img[ey-1][ex] : 8'h00;
            nxt.bot = d;
            nxt.eof = (p == W*H - 1);
            img[ey][ex] = d;
            mp   = (p + 1) % (W*H);
            msel = (ex == W-1) ? ~es : es;
            we_log.push_back(e_we);
        end else begin
            e_we    = 2'b00;
            nxt.v   = 1'b0;
            nxt.eof = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        cur = nxt;
        #1;
        reset           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        e_we    = 2'b00;
        nxt     = '0;
        mp      = 0;
        msel    = 1'b0;
        rst_was = 1'b1;
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int p);
        return 8'(16 * (p / W) + (p % W));
    endfunction

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(bus.out_valid), 64'(cur.v));
            check("out_x",     64'(bus.out_x),     64'(cur.x));
            check("out_y",     64'(bus.out_y),     64'(cur.y));
            check("out_top",   64'(bus.out_top),   64'(cur.top));
            check("out_mid",   64'(bus.out_mid),   64'(cur.mid));
            check("out_bot",   64'(bus.out_bot),   64'(cur.bot));
            check("out_eof",   64'(bus.out_eof),   64'(cur.eof));
            check("cache_we",  64'(bus.cache_we),  64'(e_we));
            check("cache_wadx", 64'(bus.cache_wadx), 64'(e_adx));
            check("cache_radx", 64'(bus.cache_radx), 64'(e_adx));
            if (e_we != 2'b00) check("cache_wdata", 64'(bus.cache_wdata), 64'(e_wdata));
            if (bus.out_valid)
                col_log.push_back('{bus.out_valid, bus.out_x, bus.out_y, bus.out_top,
                                    bus.out_mid, bus.out_bot, bus.out_eof});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int eofs;
        reset           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_data    = '0;
        mp = 0; msel = 1'b0;
        nxt = '0; cur = '0;
        e_we = '0; e_adx = '0; e_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // reset state
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out_top",   64'(bus.out_top),   64'd0);
        check("rst out_x",     64'(bus.out_x),     64'd0);
        check("rst cache_we",  64'(bus.cache_we),  64'd0);
        check("rst cache_wadx", 64'(bus.cache_wadx), 64'd0);

        // continuous frame, then a 17th pixel that wraps into a new frame
        col_log.delete(); we_log.delete();
        for (int p = 0; p < 16; p++) step(1'b1, p == 0, pat(p));
        step(1'b1, 1'b0, 8'h55);
        flush();
        check("A log size", 64'(col_log.size()), 64'd17);
        for (int p = 0; p < 8; p++) check("A rows01 top", 64'(col_log[p].top), 64'd0);
        check("A (2,2) top", 64'(col_log[10].top), 64'h02);
        check("A (2,2) mid", 64'(col_log[10].mid), 64'h12);
        check("A (2,2) bot", 64'(col_log[10].bot), 64'h22);
        check("A row0 we", 64'(we_log[0]), 64'b01);
        check("A row1 we", 64'(we_log[4]), 64'b10);
        check("A row2 we", 64'(we_log[8]), 64'b01);
        check("A row3 we", 64'(we_log[12]), 64'b10);
        eofs = 0;
        foreach (col_log[i]) if (col_log[i].eof) eofs++;
        check("A eof count", 64'(eofs), 64'd1);
        check("A eof at (3,3)", 64'(col_log[15].eof), 64'd1);
        check("A wrap x", 64'(col_log[16].x), 64'd0);
        check("A wrap y", 64'(col_log[16].y), 64'd0);
        check("A wrap top", 64'(col_log[16].top), 64'd0);
        for (int i = 0; i < 16; i++) frame_a.push_back(col_log[i]);

        // same frame with stall gaps of 1 and 3 cycles mid-row
        col_log.delete(); we_log.delete();
        for (int p = 0; p < 16; p++) begin
            step(1'b1, p == 0, pat(p));
            if (p == 5) step(1'b0, 1'b0, 8'hee);
            if (p == 9) repeat (3) step(1'b0, 1'b0, 8'hee);
        end
        flush();
        check("B log size", 64'(col_log.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            if (i < col_log.size()) check("B column vs gapless", 64'(col_log[i]), 64'(frame_a[i]));

        // frame_start arriving mid-frame at (1,2)
        col_log.delete(); we_log.delete();
        for (int p = 0; p < 9; p++) step(1'b1, p == 0, pat(p));
        step(1'b1, 1'b1, 8'h99);
        step(1'b1, 1'b0, 8'h9a);
        flush();
        check("C restart x",   64'(col_log[9].x),   64'd0);
        check("C restart y",   64'(col_log[9].y),   64'd0);
        check("C restart top", 64'(col_log[9].top), 64'd0);
        check("C restart mid", 64'(col_log[9].mid), 64'd0);
        check("C restart bot", 64'(col_log[9].bot), 64'h99);
        check("C restart we",  64'(we_log[9]),      64'b01);
        check("C next x",      64'(col_log[10].x),  64'd1);
        check("C next we",     64'(we_log[10]),     64'b01);

        // reset just before (2,3)
        for (int p = 0; p < 14; p++) step(1'b1, p == 0, pat(p));
        do_reset();
        step(1'b1, 1'b0, 8'h77);
        @(negedge clk);
        check("D post-reset out_valid", 64'(bus.out_valid), 64'd0);
        check("D post-reset out_x",     64'(bus.out_x),     64'd0);
        check("D post-reset out_y",     64'(bus.out_y),     64'd0);
        check("D post-reset out_bot",   64'(bus.out_bot),   64'd0);
        step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("D first x",   64'(bus.out_x),   64'd0);
        check("D first y",   64'(bus.out_y),   64'd0);
        check("D first top", 64'(bus.out_top), 64'd0);
        check("D first bot", 64'(bus.out_bot), 64'h77);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
